// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and helpers for the key debouncer
package key_pkg;

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    IDLE         = S_IDLE,
    PRESS_WAIT   = S_PRESS_WAIT,
    PRESSED      = S_PRESSED,
    RELEASE_WAIT = S_RELEASE_WAIT
  } key_state_e;

  // Raw pin level that means "not pressed" for the given polarity.
  function automatic logic inactive_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous bit
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button debouncer with press/release/long-press pulses
module key_debounce
  import key_pkg::*;
#(
  parameter int CNT_MAX        = 1_000_000,
  parameter int LONG_MAX       = 50_000_000,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int CW = $clog2(LONG_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MAX - 1);
  localparam logic [CW-1:0] LONG_TOP  = CW'(LONG_MAX);

  logic          key_sync;
  logic          key_act;
  key_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          level_nxt, press_nxt, release_nxt, long_nxt;

  sync_2ff #(
    .RST_VAL(inactive_level(KEY_ACTIVE_LOW))
  ) u_sync (
    .clk(sys_clk),
    .rst(sys_rst),
    .d  (key_in),
    .q  (key_sync)
  );

  assign key_act = KEY_ACTIVE_LOW ? ~key_sync : key_sync;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      key_level   <= level_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_long    <= long_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = key_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (key_act) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_act) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
          level_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        // Saturating at LONG_TOP keeps key_long to one pulse per continuous hold.
        if (!key_act) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end else if (cnt != LONG_TOP) begin
          cnt_nxt  = cnt + 1'b1;
          long_nxt = (cnt == LONG_LAST);
        end
      end
      RELEASE_WAIT: begin
        if (key_act) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
          level_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - randomized and directed bench for key_debounce
module tb_key_debounce;

  localparam int CNT_MAX  = 10;
  localparam int LONG_MAX = 40;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_in  = 1'b1;
  logic key_level, key_press, key_release, key_long;

  always #10 sys_clk = ~sys_clk;

  key_debounce #(
    .CNT_MAX       (CNT_MAX),
    .LONG_MAX      (LONG_MAX),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int n_press, n_rel, n_long, t_press, t_rel, t_long;
  int c0, c1;
  int led = 0;

  // Reference: pin history delayed two samples; a level flips once the
  // opposite value has been seen for CNT_MAX+1 consecutive evaluations.
  logic m_s1 = 1'b1, m_s2 = 1'b1;
  logic m_level = 1'b0;
  int   m_run = 0, m_hold = 0;
  logic e_press = 1'b0, e_rel = 1'b0, e_long = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model(input logic k, input logic r);
    logic a;
    e_press = 1'b0;
    e_rel   = 1'b0;
    e_long  = 1'b0;
    if (r) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_level = 1'b0; m_run = 0; m_hold = 0;
    end else begin
      a = ~m_s2;
      m_run = (a != m_level) ? m_run + 1 : 0;
      if (m_run == CNT_MAX + 1) begin
        m_run = 0;
        if (a) begin
          e_press = 1'b1; m_level = 1'b1; m_hold = 1;
        end else begin
          e_rel = 1'b1; m_level = 1'b0;
        end
      end else if (m_level && a) begin
        m_hold++;
        if (m_hold == LONG_MAX + 1) e_long = 1'b1;
      end
      if (!a) m_hold = 0;
      m_s2 = m_s1;
      m_s1 = k;
    end
  endtask

  task automatic step(input logic k, input logic r);
    key_in  = k;
    sys_rst = r;
    @(negedge sys_clk);
    cyc++;
    model(k, r);
    check("key_level", key_level, m_level);
    check("key_press", key_press, e_press);
    check("key_release", key_release, e_rel);
    check("key_long", key_long, e_long);
    if (key_press)   begin n_press++; t_press = cyc; led ^= 1; end
    if (key_release) begin n_rel++;   t_rel   = cyc; end
    if (key_long)    begin n_long++;  t_long  = cyc; end
  endtask

  task automatic hold(input logic k, input int n);
    repeat (n) step(k, 1'b0);
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_long = 0;
    t_press = -1; t_rel = -1; t_long = -1;
  endtask

  initial begin
    clear_counts();
    repeat (20) step(1'($urandom_range(0, 1)), 1'b1);
    step(1'b1, 1'b1);
    hold(1'b1, 20);
    check("rst_no_press", n_press, 0);

    clear_counts();
    c0 = cyc + 1;
    hold(1'b0, 30);
    check("press_latency", t_press - c0, CNT_MAX + 2);
    check("press_count", n_press, 1);
    check("no_long_30", n_long, 0);
    hold(1'b1, 20);

    clear_counts();
    hold(1'b0, 5); hold(1'b1, 3); hold(1'b0, 4); hold(1'b1, 20);
    check("bounce_no_press", n_press, 0);
    hold(1'b0, 12); hold(1'b1, 20);
    check("low12_one_press", n_press, 1);

    clear_counts();
    hold(1'b0, 60);
    c1 = cyc + 1;
    hold(1'b1, 20);
    check("long_count", n_long, 1);
    check("long_delay", t_long - t_press, LONG_MAX);
    check("release_latency", t_rel - c1, CNT_MAX + 2);
    check("level_after_rel", key_level, 0);

    hold(1'b0, 15);
    clear_counts();
    hold(1'b1, 6); hold(1'b0, 20);
    check("rel_bounce_none", n_rel, 0);
    check("rel_bounce_level", key_level, 1);
    hold(1'b1, 20);

    hold(1'b0, 5);
    clear_counts();
    led = 0;
    repeat (3) step(1'b0, 1'b1);
    c0 = cyc + 1;
    hold(1'b0, 20);
    check("rst_repress_latency", t_press - c0, CNT_MAX + 2);
    check("led_toggles_once", led, 1);
    hold(1'b1, 20);

    repeat (40) begin
      logic k;
      int   len;
      k   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 55);
      for (int i = 0; i < len; i++)
        step(($urandom_range(0, 7) == 0) ? ~k : k, ($urandom_range(0, 199) == 0));
    end
    hold(1'b1, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
